uart_tx: RTL

- UART transmitter, 8N1 framing, LSB first, fixed baud via clock-divider parameter.
- Transmit-side counterpart to the team's UART receiver; same CLKS_PER_BIT convention (5208 = 9600 baud at 50 MHz).
- Parallel byte accepted over a valid/ready handshake from the system side; serial line driven on tx.

---
 rtl/uart_tx.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter, LSB first, fixed baud set by CLKS_PER_BIT.
//
// A byte is taken from the system side over a valid/ready handshake while the
// transmitter is idle. The byte is then sent on the registered serial line:
// one start bit, eight data bits, an optional parity bit and one stop bit.
// A single DONE cycle follows the stop bit, and then the transmitter is idle
// again.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2); 5208 = 9600 baud @ 50 MHz
//   PARITY_ODD    0 = even parity, 1 = odd parity (used only with the macro)
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, a parity bit is inserted after D7
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any frame in flight
//   tx_data   byte to send, sampled only on an accepted handshake
//   tx_valid  request to send tx_data
//   tx_ready  high only while idle; handshake is tx_valid & tx_ready
//   tx        serial output, registered, idles high
//   busy      high from the cycle after acceptance through the DONE cycle
//   done      one-cycle pulse after the stop bit completes
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // Reject parameter values outside the legal range when the design is elaborated.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              baud_last;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    assign tx_ready  = (state == S_IDLE);
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shift    <= tx_data;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        // The parity bit is taken from the whole byte at acceptance,
                        // so it is ready before the shift register is consumed.
                        parity   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            // tx is registered, so the next bit is shift[1], one bit
                            // ahead of the value that the shift leaves in shift[0].
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
